// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO drain reader: FSM state encoding and
// the level-counter width rule.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    // The level counter needs one bit more than the FIFO pointer so that
    // a completely full FIFO (level == DEPTH) is representable.
    localparam int unsigned LEVEL_EXTRA_BITS = 1;

    function automatic int unsigned level_w(input int unsigned addr_w);
        return addr_w + LEVEL_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output skid buffer. Captures FIFO read data one cycle after
// each pop and presents the oldest entry with a valid/ready handshake.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             rd_fire;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = out_valid ? head_q : '0;
    assign count     = cnt_q;
    assign rd_fire   = out_valid && rd_ready;

    // Entry storage and occupancy; head always holds the oldest word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({wr_en, rd_fire})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= wr_data;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        tail_q <= wr_data;
                        cnt_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Write and read together: count is unchanged, order kept.
                    if (cnt_q == 2'd1) begin
                        head_q <= wr_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= wr_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// FIFO drain reader: tracks attached FIFO occupancy, issues pops for a
// commanded number of words and streams them out through a skid buffer.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDRESSWIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        rd_data,
    output logic                    pop,
    input  logic                    cmd_valid,
    input  logic [ADDRESSWIDTH:0]   cmd_len,
    output logic                    cmd_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic                    done,
    output logic [ADDRESSWIDTH:0]   level,
    output logic                    empty,
    output logic                    ovf_err
);

    localparam int unsigned LW = level_w(ADDRESSWIDTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    rd_state_t       state_q;
    rd_state_t       state_d;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   remaining_q;
    logic            in_flight_q;
    logic            ovf_q;
    logic            done_q;
    logic            done_d;
    logic            load_rem;
    logic [1:0]      skid_count;
    logic            xfer;
    logic [1:0]      occupancy;

    assign xfer = out_valid && out_ready;

    // The word leaving the buffer this cycle frees its slot now, so it is
    // excluded from the occupancy; this is what sustains one pop per cycle
    // under continuous out_ready while still never overfilling two entries.
    assign occupancy = (skid_count - {1'b0, xfer}) + {1'b0, in_flight_q};

    assign pop = (state_q == DRAIN) && (level_q != '0) &&
                 (remaining_q != '0) && (occupancy < 2'd2);

    assign cmd_ready = (state_q == IDLE);
    assign level     = level_q;
    assign empty     = (level_q == '0);
    assign ovf_err   = ovf_q;
    assign done      = done_q;

    // FSM state, completion pulse and word countdown.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load_rem) begin
                remaining_q <= cmd_len;
            end else if (pop) begin
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    // Next-state and command handling.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        load_rem = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        load_rem = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && (remaining_q == LW'(1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((skid_count == 2'd0) && !in_flight_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO occupancy tracking and sticky overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push && (level_q == DEPTH_L)) begin
                ovf_q <= 1'b1;
            end
            if (push && !pop && (level_q != DEPTH_L)) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Marks that FIFO read data arrives on rd_data this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= pop;
        end
    end

    fifo_reader_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (in_flight_q),
        .wr_data   (rd_data),
        .rd_ready  (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (skid_count)
    );

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WIDTH, default 16, data word width.
REQ-002 Parameter DEPTH, default 16, entry count of the attached FIFO.
REQ-003 Parameter ADDRESSWIDTH, default 5, FIFO pointer width; level counter is ADDRESSWIDTH+1 bits.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 push  in  1  writer's per-cycle write strobe into the FIFO (mirrors FIFO new_data).
REQ-008 rd_data  in  WIDTH  FIFO registered read data, valid the cycle after pop.
REQ-009 pop  out  1  read strobe to FIFO (drives FIFO out_data).
REQ-010 cmd_valid  in  1  drain request.
REQ-011 cmd_len  in  ADDRESSWIDTH+1  words to drain.
REQ-012 cmd_ready  out  1  high in IDLE only.
REQ-013 out_valid  out  1  output word available.
REQ-014 out_data  out  WIDTH  output word.
REQ-015 out_ready  in  1  consumer accepts.
REQ-016 done  out  1  one-cycle pulse at drain completion.
REQ-017 level  out  ADDRESSWIDTH+1  current FIFO occupancy.
REQ-018 empty  out  1  level==0, combinational.
REQ-019 ovf_err  out  1  sticky: push seen while level==DEPTH.

Function
REQ-020 level SHALL +1 on push only, -1 on pop only, hold on both or neither; push at level==DEPTH SHALL not increment and SHALL set ovf_err.
REQ-021 pop SHALL be combinational: state==DRAIN && level!=0 && remaining!=0 && (buffered + in_flight) < 2.
REQ-022 in_flight SHALL be a 1-bit register equal to the previous cycle's pop; rd_data SHALL be written into a 2-entry output skid buffer when in_flight==1.
REQ-023 out_valid SHALL be high when the skid buffer is non-empty; out_data SHALL be the oldest entry; transfer occurs on out_valid && out_ready.
REQ-024 Simultaneous buffer write and transfer SHALL keep order and count; the buffer SHALL never overflow (guaranteed by REQ-021).
REQ-025 Sustained throughput SHALL be one word per cycle while out_ready=1 and level>0.
REQ-026 FSM states IDLE, DRAIN, FLUSH; reset state IDLE.
REQ-027 IDLE: on cmd_valid with cmd_len!=0, load remaining=cmd_len, go DRAIN; with cmd_len==0, pulse done next cycle, stay IDLE.
REQ-028 DRAIN: remaining SHALL decrement on each pop; when remaining reaches 0 go FLUSH.
REQ-029 FLUSH: when skid buffer empty and in_flight==0, pulse done and go IDLE.
REQ-030 DRAIN with level==0 SHALL stall indefinitely (no timeout); pop SHALL remain low.
REQ-031 cmd_valid outside IDLE SHALL be ignored.
REQ-032 pop and level updates SHALL be independent of out_ready except through REQ-021 back-pressure.

Reset
REQ-033 On reset low: state=IDLE, level=0, remaining=0, in_flight=0, skid buffer emptied, out_valid=0, out_data=0, done=0, ovf_err=0, pop=0, cmd_ready=1.
REQ-034 Reset mid-drain SHALL discard in-flight and buffered words with no done pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, DRAIN=2'd1, FLUSH=2'd2) and the level-width constant.
REQ-036 The 2-entry skid buffer SHALL be a sub-module named fifo_reader_skid; FSM, level counter and pop logic stay in fifo_reader.

Verification
REQ-037 Push 0x0001..0x0005 (level=5), cmd_len=5, out_ready=1 -> pops on 5 consecutive cycles, out_data 0x0001..0x0005 in order, level=0, single done pulse.
REQ-038 level=4, cmd_len=4, out_ready=0 for 10 cycles -> exactly 2 pops, out_valid=1 holding first word; out_ready=1 -> remaining 2 words follow, done once.
REQ-039 cmd_len=3, level=0, then push one word every 4 cycles -> pop one cycle after each push, 3 words out, done after the third.
REQ-040 Push and pop same cycle at level=7 -> level stays 7; 17 pushes from reset with no drain -> level=16, ovf_err=1.
REQ-041 Reset asserted with 1 word in flight and 1 buffered -> out_valid=0, level=0, state IDLE, no done pulse.
REQ-042 cmd_len=0 in IDLE -> done pulse next cycle, no pop, cmd_ready stays 1.
